// File: rtl/led_uart_reporter_if.sv
`default_nettype none
// ============================================================================
//  Module      : led_uart_reporter_if
//  Description : Signal bundle between the MiniAlu LED output register and
//                the LED UART reporter.
//                  iData  [7:0] LED value sampled by the reporter
//                  oTx          UART serial line, idles high
//                  oBusy        high for the whole frame (start..stop)
//                master modport: the side that supplies iData and observes
//                the serial line; slave modport: the reporter itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface led_uart_reporter_if;
    logic [7:0] iData;
    logic       oTx;
    logic       oBusy;

    modport master (
        output iData,
        input  oTx,
        input  oBusy
    );

    modport slave (
        input  iData,
        output oTx,
        output oBusy
    );
endinterface
`default_nettype wire

// File: rtl/led_uart_reporter.sv
`default_nettype none
// ============================================================================
//  Module      : led_uart_reporter
//  Description : Watches an 8-bit LED value and sends every new value as a
//                UART frame (8N1, or 8E1 when LED_UART_PARITY_EN is defined).
//                A one-entry latest-value buffer coalesces changes that land
//                while a frame is in flight, so the last LED state always
//                reaches the host.
//  Ports       : Clock        system clock, rising edge
//                Reset        synchronous, active-low
//                bus.iData    LED value in
//                bus.oTx      UART serial out (registered, idles high)
//                bus.oBusy    high from start bit through last stop cycle
//  Parameters  : CLKS_PER_BIT clock cycles per UART bit (>= 2)
//  Macros      : LED_UART_PARITY_EN  adds an even-parity bit before stop
//  Revision    : 1.0  initial release
// ============================================================================
module led_uart_reporter #(
    parameter int CLKS_PER_BIT = 434
) (
    input  wire                 Clock,
    input  wire                 Reset,
    led_uart_reporter_if.slave  bus
);

    localparam int                c_baud_w    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef LED_UART_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t              r_state_q,   w_state_d;
    logic [7:0]          r_last_q,    w_last_d;
    logic [7:0]          r_hold_q,    w_hold_d;
    logic                r_pending_q, w_pending_d;
    logic [7:0]          r_shift_q,   w_shift_d;
    logic [2:0]          r_bit_cnt_q, w_bit_cnt_d;
    logic [c_baud_w-1:0] r_baud_q,    w_baud_d;
    logic                r_tx_q,      w_tx_d;
    logic                r_busy_q,    w_busy_d;
`ifdef LED_UART_PARITY_EN
    logic                r_par_q,     w_par_d;
`endif
    logic                w_bit_end;

    always_comb begin
        w_state_d   = r_state_q;
        w_last_d    = r_last_q;
        w_hold_d    = r_hold_q;
        w_pending_d = r_pending_q;
        w_shift_d   = r_shift_q;
        w_bit_cnt_d = r_bit_cnt_q;
        w_baud_d    = r_baud_q;
        w_tx_d      = r_tx_q;
        w_busy_d    = r_busy_q;
`ifdef LED_UART_PARITY_EN
        w_par_d     = r_par_q;
`endif
        w_bit_end   = (r_baud_q == c_baud_last);

        // Outputs are registered: each transition also sets the line level
        // for the state being entered, so oTx/oBusy change on that same edge.
        case (r_state_q)
            S_IDLE: begin
                w_tx_d   = 1'b1;
                w_busy_d = 1'b0;
                w_baud_d = '0;
                if (r_pending_q) begin
                    w_shift_d   = r_hold_q;
                    w_pending_d = 1'b0;
`ifdef LED_UART_PARITY_EN
                    // Latched at load because the shifter is consumed by DATA.
                    w_par_d     = ^r_hold_q;
`endif
                    w_state_d   = S_START;
                    w_tx_d      = 1'b0;
                    w_busy_d    = 1'b1;
                end
            end

            S_START: begin
                if (w_bit_end) begin
                    w_baud_d  = '0;
                    w_state_d = S_DATA;
                    w_tx_d    = r_shift_q[0];
                end else begin
                    w_baud_d  = r_baud_q + c_baud_w'(1);
                end
            end

            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_d    = '0;
                    w_shift_d   = {1'b0, r_shift_q[7:1]};
                    w_bit_cnt_d = r_bit_cnt_q + 3'd1;   // wraps 7 -> 0 on exit
                    if (r_bit_cnt_q == 3'd7) begin
`ifdef LED_UART_PARITY_EN
                        w_state_d = S_PARITY;
                        w_tx_d    = r_par_q;
`else
                        w_state_d = S_STOP;
                        w_tx_d    = 1'b1;
`endif
                    end else begin
                        // Next bit is what shift[0] becomes after this shift.
                        w_tx_d = r_shift_q[1];
                    end
                end else begin
                    w_baud_d = r_baud_q + c_baud_w'(1);
                end
            end

`ifdef LED_UART_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_baud_d  = '0;
                    w_state_d = S_STOP;
                    w_tx_d    = 1'b1;
                end else begin
                    w_baud_d  = r_baud_q + c_baud_w'(1);
                end
            end
`endif

            S_STOP: begin
                if (w_bit_end) begin
                    w_baud_d  = '0;
                    w_state_d = S_IDLE;
                    w_tx_d    = 1'b1;
                    w_busy_d  = 1'b0;
                end else begin
                    w_baud_d  = r_baud_q + c_baud_w'(1);
                end
            end

            default: begin
                w_state_d = S_IDLE;
                w_baud_d  = '0;
                w_tx_d    = 1'b1;
                w_busy_d  = 1'b0;
            end
        endcase

        // Change detect runs in every state and comes last so that a change
        // on the same edge IDLE consumes rHold re-arms the pending flag with
        // the new value (the frame already took the old one).
        if (bus.iData != r_last_q) begin
            w_last_d    = bus.iData;
            w_hold_d    = bus.iData;
            w_pending_d = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state_q   <= S_IDLE;
            r_last_q    <= 8'h00;
            r_hold_q    <= 8'h00;
            r_pending_q <= 1'b0;
            r_shift_q   <= 8'h00;
            r_bit_cnt_q <= 3'd0;
            r_baud_q    <= '0;
            r_tx_q      <= 1'b1;
            r_busy_q    <= 1'b0;
`ifdef LED_UART_PARITY_EN
            r_par_q     <= 1'b0;
`endif
        end else begin
            r_state_q   <= w_state_d;
            r_last_q    <= w_last_d;
            r_hold_q    <= w_hold_d;
            r_pending_q <= w_pending_d;
            r_shift_q   <= w_shift_d;
            r_bit_cnt_q <= w_bit_cnt_d;
            r_baud_q    <= w_baud_d;
            r_tx_q      <= w_tx_d;
            r_busy_q    <= w_busy_d;
`ifdef LED_UART_PARITY_EN
            r_par_q     <= w_par_d;
`endif
        end
    end

    assign bus.oTx   = r_tx_q;
    assign bus.oBusy = r_busy_q;

endmodule
`default_nettype wire
